mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive fetch losses that forces a fetch grant.
REQ-002 Parameter IO_SEL, default 2'b11: value of addr[17:16] that marks an I/O address.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; low freezes all state and outputs.
REQ-006 rollback  in  1  pipeline flush pulse.
REQ-007 if_req / ld_req / st_req  in  1  level requests; each is held until its done pulse.
REQ-008 if_addr / ld_addr / st_addr  in  32  request addresses.
REQ-009 ld_op / st_op  in  6  load and store opcodes (LB/LH/LW/LBU/LHU, SB/SH/SW); forwarded unchanged.
REQ-010 st_data  in  32  store data.
REQ-011 ld_io_ok  in  1  high when the load is at the ROB head (I/O load permitted).
REQ-012 if_done / ld_done / st_done  out  1  one-cycle completion pulses.
REQ-013 if_data / ld_data  out  32  result data; valid in the done cycle.
REQ-014 mc_valid  out  1  downstream request valid.
REQ-015 mc_kind  out  2  downstream request kind: 0 fetch, 1 load, 2 store.
REQ-016 mc_addr / mc_wdata  out  32  downstream address and write data.
REQ-017 mc_op  out  6  downstream opcode.
REQ-018 mc_ack  in  1  downstream accepted the request (one-cycle pulse).
REQ-019 mc_done  in  1  downstream finished (one-cycle pulse).
REQ-020 mc_rdata  in  32  downstream read data; valid with mc_done.

Function
REQ-021 The FSM SHALL use four states: IDLE, ISSUE, WAIT, DRAIN.
REQ-022 IDLE, one or more eligible requests: grant one, register its address/data/op onto mc_*, set mc_valid, go to ISSUE; mc_valid is high in the cycle after the request is sampled.
REQ-023 Priority SHALL be store > load > fetch.
REQ-024 Exception: if the fetch loss counter has reached STARVE_LIMIT, fetch SHALL beat load; a pending store still wins.
REQ-025 The fetch loss counter (3 bits, saturating) SHALL increment on each grant to another requester while if_req is high, and SHALL clear on a fetch grant or when if_req is low.
REQ-026 A load with addr[17:16]==IO_SEL SHALL be ineligible while ld_io_ok is low.
REQ-027 ISSUE: hold mc_* stable until mc_ack, then clear mc_valid and go to WAIT.
REQ-028 WAIT: on mc_done, latch mc_rdata into the granted requester's data output, pulse its done for one cycle, and return to IDLE.
REQ-029 In the cycle a done pulse is high, that requester's req SHALL be masked from arbitration.
REQ-030 Rollback while a load or fetch is in ISSUE or WAIT: suppress its done. From ISSUE, withdraw mc_valid and return to IDLE if mc_ack has not arrived; otherwise go to DRAIN.
REQ-031 DRAIN: wait for mc_done, discard the data, return to IDLE with no done pulse.
REQ-032 Rollback while a store is in flight: the store SHALL complete normally and st_done SHALL pulse, because stores are committed.
REQ-033 Rollback in IDLE: no grant in that cycle.
REQ-034 rdy low: FSM, counter and all outputs held; done pulses are not repeated.

Reset
REQ-035 On rst: FSM to IDLE, counter 0, all outputs 0 (mc_valid, all done pulses, data, mc_addr, mc_wdata, mc_op, mc_kind). rst SHALL override rdy and rollback.
REQ-036 Reset mid-transaction SHALL abandon it silently; no done pulse afterward.

Structure
REQ-037 State encodings, mc_kind codes, the IO_SEL default and the opcode macros SHALL live in the shared defines package.
REQ-038 A sub-module, mem_arb_pick, is natural: a combinational priority/starvation picker producing a one-hot grant. Everything else stays in mem_arbiter.

Verification
REQ-039 Scenario: st_req, ld_req and if_req all raised at T -> mc_kind=2 at T+1; after its done, load; fetch last.
REQ-040 Scenario: ld_req held continuously, if_req held, stores absent -> fetch is granted after exactly 4 load grants.
REQ-041 Scenario: ld_addr=0x00030000, ld_io_ok=0 for 10 cycles, if_req high -> fetch served, load not issued; ld_io_ok=1 -> load issued next IDLE.
REQ-042 Scenario: load in WAIT, rollback pulse, mc_done 3 cycles later with mc_rdata=0xDEADBEEF -> no ld_done, state IDLE after drain.
REQ-043 Scenario: SW st_addr=0x100, st_data=0x12345678 in WAIT, rollback -> mc_done still yields st_done one cycle later.
REQ-044 Scenario: rst asserted in ISSUE -> next cycle mc_valid=0, all outputs 0, no done pulse ever follows.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, request kinds,
// grant bit positions, the default I/O window select and the load/store opcodes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_t;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  localparam int GNT_IF = 0;
  localparam int GNT_LD = 1;
  localparam int GNT_ST = 2;

  localparam logic [5:0] OP_LB  = 6'h00;
  localparam logic [5:0] OP_LH  = 6'h01;
  localparam logic [5:0] OP_LW  = 6'h02;
  localparam logic [5:0] OP_LBU = 6'h04;
  localparam logic [5:0] OP_LHU = 6'h05;
  localparam logic [5:0] OP_SB  = 6'h08;
  localparam logic [5:0] OP_SH  = 6'h09;
  localparam logic [5:0] OP_SW  = 6'h0A;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-controller-side signals of the arbiter. The arbiter
// uses the slave view; whoever drives requests and models memory uses master.
interface mem_arbiter_if;

  logic        rdy;
  logic        rollback;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr;
  logic [5:0]  ld_op, st_op;
  logic [31:0] st_data;
  logic        ld_io_ok;
  logic        if_done, ld_done, st_done;
  logic [31:0] if_data, ld_data;
  logic        mc_valid;
  logic [1:0]  mc_kind;
  logic [31:0] mc_addr, mc_wdata;
  logic [5:0]  mc_op;
  logic        mc_ack, mc_done;
  logic [31:0] mc_rdata;

  modport slave (
    input  rdy, rollback, if_req, ld_req, st_req, if_addr, ld_addr, st_addr,
           ld_op, st_op, st_data, ld_io_ok, mc_ack, mc_done, mc_rdata,
    output if_done, ld_done, st_done, if_data, ld_data,
           mc_valid, mc_kind, mc_addr, mc_wdata, mc_op
  );

  modport master (
    output rdy, rollback, if_req, ld_req, st_req, if_addr, ld_addr, st_addr,
           ld_op, st_op, st_data, ld_io_ok, mc_ack, mc_done, mc_rdata,
    input  if_done, ld_done, st_done, if_data, ld_data,
           mc_valid, mc_kind, mc_addr, mc_wdata, mc_op
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational picker: store > load > fetch, except a starved fetch beats a load.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_if_elig,
  input  logic       i_ld_elig,
  input  logic       i_st_elig,
  input  logic       i_starved,
  output logic [2:0] o_grant
);

  always_comb begin
    // NOTE: default first so every path assigns o_grant and no latch is inferred.
    o_grant = '0;
    if (i_st_elig)                   o_grant[GNT_ST] = 1'b1;
    else if (i_starved && i_if_elig) o_grant[GNT_IF] = 1'b1;
    else if (i_ld_elig)              o_grant[GNT_LD] = 1'b1;
    else if (i_if_elig)              o_grant[GNT_IF] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch/load/store requesters onto one memory-controller port, with
// fetch starvation relief, I/O-load gating and rollback handling.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         STARVE_LIMIT = 4,  // legal range 1..7 (3-bit counter)
  parameter logic [1:0] IO_SEL       = IO_SEL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] STARVE_CNT = 3'(STARVE_LIMIT);

  state_t      r_state;
  kind_t       r_kind;
  logic [2:0]  r_cnt;
  logic        r_mc_valid;
  logic [31:0] r_mc_addr, r_mc_wdata;
  logic [5:0]  r_mc_op;
  logic        r_if_done, r_ld_done, r_st_done;
  logic [31:0] r_if_data, r_ld_data;

  logic        w_ld_io_blocked, w_if_elig, w_ld_elig, w_st_elig, w_starved;
  logic        w_flush, w_hold_off;
  logic [2:0]  w_grant;

  assign w_ld_io_blocked = (bus.ld_addr[17:16] == IO_SEL) && !bus.ld_io_ok;
  assign w_if_elig = bus.if_req && !r_if_done;
  assign w_ld_elig = bus.ld_req && !r_ld_done && !w_ld_io_blocked;
  assign w_st_elig = bus.st_req && !r_st_done;
  assign w_starved = (r_cnt >= STARVE_CNT);
  // Stores are already committed, so a rollback never cancels them.
  assign w_flush   = bus.rollback && (r_kind != KIND_STORE);
  // A done cycle is a one-cycle bubble, letting a requester that keeps its
  // request up compete again on equal terms in the following cycle.
  assign w_hold_off = bus.rollback || r_if_done || r_ld_done || r_st_done;

  mem_arb_pick u_pick (
    .i_if_elig (w_if_elig),
    .i_ld_elig (w_ld_elig),
    .i_st_elig (w_st_elig),
    .i_starved (w_starved),
    .o_grant   (w_grant)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_kind     <= KIND_FETCH;
      r_cnt      <= '0;
      r_mc_valid <= 1'b0;
      r_mc_addr  <= '0;
      r_mc_wdata <= '0;
      r_mc_op    <= '0;
      r_if_done  <= 1'b0;
      r_ld_done  <= 1'b0;
      r_st_done  <= 1'b0;
      r_if_data  <= '0;
      r_ld_data  <= '0;
    end else begin
      // Done pulses never stretch, even across a stall.
      r_if_done <= 1'b0;
      r_ld_done <= 1'b0;
      r_st_done <= 1'b0;
      if (bus.rdy) begin
        if (!bus.if_req) r_cnt <= '0;
        case (r_state)
          IDLE: begin
            if (!w_hold_off && |w_grant) begin
              r_mc_valid <= 1'b1;
              r_state    <= ISSUE;
              if (w_grant[GNT_ST]) begin
                r_kind     <= KIND_STORE;
                r_mc_addr  <= bus.st_addr;
                r_mc_wdata <= bus.st_data;
                r_mc_op    <= bus.st_op;
              end else if (w_grant[GNT_LD]) begin
                r_kind     <= KIND_LOAD;
                r_mc_addr  <= bus.ld_addr;
                r_mc_wdata <= '0;
                r_mc_op    <= bus.ld_op;
              end else begin
                r_kind     <= KIND_FETCH;
                r_mc_addr  <= bus.if_addr;
                r_mc_wdata <= '0;
                r_mc_op    <= '0;
              end
              if (w_grant[GNT_IF])                r_cnt <= '0;
              else if (bus.if_req && r_cnt != '1) r_cnt <= r_cnt + 3'd1;
            end
          end
          ISSUE: begin
            if (w_flush) begin
              r_mc_valid <= 1'b0;
              r_state    <= bus.mc_ack ? DRAIN : IDLE;
            end else if (bus.mc_ack) begin
              r_mc_valid <= 1'b0;
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (bus.mc_done) begin
              r_state <= IDLE;
              if (!w_flush) begin
                case (r_kind)
                  KIND_FETCH: begin r_if_done <= 1'b1; r_if_data <= bus.mc_rdata; end
                  KIND_LOAD:  begin r_ld_done <= 1'b1; r_ld_data <= bus.mc_rdata; end
                  default:    r_st_done <= 1'b1;
                endcase
              end
            end else if (w_flush) begin
              r_state <= DRAIN;
            end
          end
          DRAIN: if (bus.mc_done) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mc_valid = r_mc_valid;
  assign bus.mc_kind  = r_kind;
  assign bus.mc_addr  = r_mc_addr;
  assign bus.mc_wdata = r_mc_wdata;
  assign bus.mc_op    = r_mc_op;
  assign bus.if_done  = r_if_done;
  assign bus.ld_done  = r_ld_done;
  assign bus.st_done  = r_st_done;
  assign bus.if_data  = r_if_data;
  assign bus.ld_data  = r_ld_data;

endmodule
